// File: rtl/z80_mcycle_rd.sv
// Z80 memory-read machine cycle: opcode fetch (M1 with refresh) or plain read,
// with WAIT-state insertion. One clock equals one T-state; every output is registered.
module z80_mcycle_rd (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        m1,
    input  logic [15:0] addr,
    input  logic [15:0] ir,
    input  logic [7:0]  data_in,
    input  logic        wait_n,
    output logic [15:0] addr_bus,
    output logic        mreq_n,
    output logic        rd_n,
    output logic        m1_n,
    output logic        rfsh_n,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [7:0]  wait_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TW,
        T3,
        T4
    } state_t;

    state_t      state_q, state_d;
    logic        m1_q, m1_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  wctr_q, wctr_d;

    logic [15:0] addr_bus_d;
    logic        mreq_n_d, rd_n_d, m1_n_d, rfsh_n_d, busy_d, done_d;
    logic [7:0]  rdata_d, wait_cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            m1_q     <= 1'b0;
            addr_q   <= 16'h0000;
            ir_q     <= 16'h0000;
            wctr_q   <= 8'h00;
            addr_bus <= 16'h0000;
            mreq_n   <= 1'b1;
            rd_n     <= 1'b1;
            m1_n     <= 1'b1;
            rfsh_n   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'h00;
            wait_cnt <= 8'h00;
        end else begin
            state_q  <= state_d;
            m1_q     <= m1_d;
            addr_q   <= addr_d;
            ir_q     <= ir_d;
            wctr_q   <= wctr_d;
            addr_bus <= addr_bus_d;
            mreq_n   <= mreq_n_d;
            rd_n     <= rd_n_d;
            m1_n     <= m1_n_d;
            rfsh_n   <= rfsh_n_d;
            busy     <= busy_d;
            done     <= done_d;
            rdata    <= rdata_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        m1_d       = m1_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
        wctr_d     = wctr_q;
        rdata_d    = rdata;
        wait_cnt_d = wait_cnt;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = T1;
                    m1_d    = m1;
                    addr_d  = addr;
                    ir_d    = ir;
                    wctr_d  = 8'h00;
                end
            end
            T1: state_d = T2;
            T2, TW: begin
                if (!wait_n) begin
                    state_d = TW;
                    if (wctr_q != 8'hFF)
                        wctr_d = wctr_q + 8'h01;
                end else begin
                    state_d = T3;
                    if (m1_q)
                        rdata_d = data_in;
                end
            end
            T3: begin
                if (m1_q) begin
                    state_d = T4;
                end else begin
                    state_d    = IDLE;
                    rdata_d    = data_in;
                    done_d     = 1'b1;
                    wait_cnt_d = wctr_q;
                end
            end
            T4: begin
                state_d    = IDLE;
                done_d     = 1'b1;
                wait_cnt_d = wctr_q;
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are decoded from the state being entered so they line up with it.
        addr_bus_d = addr_bus;
        mreq_n_d   = 1'b1;
        rd_n_d     = 1'b1;
        m1_n_d     = 1'b1;
        rfsh_n_d   = 1'b1;
        busy_d     = 1'b0;

        case (state_d)
            T1, T2, TW: begin
                addr_bus_d = addr_d;
                mreq_n_d   = 1'b0;
                rd_n_d     = 1'b0;
                m1_n_d     = ~m1_d;
                busy_d     = 1'b1;
            end
            T3: begin
                busy_d   = 1'b1;
                mreq_n_d = 1'b0;
                if (m1_d) begin
                    addr_bus_d = ir_d;
                    rfsh_n_d   = 1'b0;
                end else begin
                    addr_bus_d = addr_d;
                    rd_n_d     = 1'b0;
                end
            end
            T4: begin
                addr_bus_d = ir_d;
                mreq_n_d   = 1'b0;
                rfsh_n_d   = 1'b0;
                busy_d     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_z80_mcycle_rd.sv
// Directed self-checking bench for z80_mcycle_rd: plain read, waits, M1 fetch,
// back-to-back requests, mid-cycle reset and wait counter saturation.
module tb_z80_mcycle_rd;

    logic        clk;
    logic        reset_n;
    logic        req;
    logic        m1;
    logic [15:0] addr;
    logic [15:0] ir;
    logic [7:0]  data_in;
    logic        wait_n;
    logic [15:0] addr_bus;
    logic        mreq_n, rd_n, m1_n, rfsh_n;
    logic        busy;
    logic        done;
    logic [7:0]  rdata;
    logic [7:0]  wait_cnt;

    int checks = 0;
    int failures = 0;

    z80_mcycle_rd dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .m1       (m1),
        .addr     (addr),
        .ir       (ir),
        .data_in  (data_in),
        .wait_n   (wait_n),
        .addr_bus (addr_bus),
        .mreq_n   (mreq_n),
        .rd_n     (rd_n),
        .m1_n     (m1_n),
        .rfsh_n   (rfsh_n),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .wait_cnt (wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector order: {mreq_n, rd_n, m1_n, rfsh_n, busy, done}
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = 1'b0; m1 = 1'b0; addr = 16'h0; ir = 16'h0;
        data_in = 8'h00; wait_n = 1'b1;
        tick(); tick();
        checks++;
        if ({mreq_n, rd_n, m1_n, rfsh_n, busy, done} !== 6'b111100) begin
            failures++;
            $display("FAIL reset_strobes got=%b want=111100", {mreq_n, rd_n, m1_n, rfsh_n, busy, done});
        end
        checks++;
        if ({addr_bus, rdata, wait_cnt} !== 32'h0) begin
            failures++;
            $display("FAIL reset_values got=%h want=00000000", {addr_bus, rdata, wait_cnt});
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_plain_read();
        req = 1'b1; m1 = 1'b0; addr = 16'h1234; ir = 16'hAAAA; data_in = 8'h5A; wait_n = 1'b1;
        tick();
        req = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            checks++;
            if ({mreq_n, rd_n, m1_n, rfsh_n, busy, done} !== 6'b001110 || addr_bus !== 16'h1234) begin
                failures++;
                $display("FAIL plain_t%0d got=%b addr=%h want=001110 addr=1234", n,
                         {mreq_n, rd_n, m1_n, rfsh_n, busy, done}, addr_bus);
            end
            tick();
        end
        checks++;
        if ({mreq_n, rd_n, m1_n, rfsh_n, busy, done} !== 6'b111101 || rdata !== 8'h5A || wait_cnt !== 8'h00) begin
            failures++;
            $display("FAIL plain_done got=%b rdata=%h wcnt=%0d want=111101 rdata=5a wcnt=0",
                     {mreq_n, rd_n, m1_n, rfsh_n, busy, done}, rdata, wait_cnt);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || addr_bus !== 16'h1234) begin
            failures++;
            $display("FAIL plain_idle got done=%b busy=%b addr=%h want done=0 busy=0 addr=1234",
                     done, busy, addr_bus);
        end
    endtask

    task automatic test_wait_states();
        int done_at;
        done_at = 0;
        req = 1'b1; m1 = 1'b0; addr = 16'h8000; data_in = 8'hC3; wait_n = 1'b1;
        tick();
        req = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (done) begin
                done_at = n;
                break;
            end
            if (n == 3 || n == 4) begin
                checks++;
                if ({mreq_n, rd_n, m1_n, rfsh_n, busy} !== 5'b00111 || addr_bus !== 16'h8000) begin
                    failures++;
                    $display("FAIL tw_hold clk%0d got=%b addr=%h want=00111 addr=8000", n,
                             {mreq_n, rd_n, m1_n, rfsh_n, busy}, addr_bus);
                end
            end
            wait_n = (n == 2 || n == 3) ? 1'b0 : 1'b1;
            tick();
        end
        wait_n = 1'b1;
        checks++;
        if (done_at !== 6) begin
            failures++;
            $display("FAIL wait_latency got=%0d want=6", done_at);
        end
        checks++;
        if (rdata !== 8'hC3 || wait_cnt !== 8'd2) begin
            failures++;
            $display("FAIL wait_result got rdata=%h wcnt=%0d want rdata=c3 wcnt=2", rdata, wait_cnt);
        end
    endtask

    task automatic test_m1_fetch();
        tick();
        req = 1'b1; m1 = 1'b1; addr = 16'h0100; ir = 16'h3F07; data_in = 8'h0A; wait_n = 1'b1;
        tick();
        req = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            checks++;
            if ({mreq_n, rd_n, m1_n, rfsh_n, busy} !== 5'b00011 || addr_bus !== 16'h0100) begin
                failures++;
                $display("FAIL m1_t%0d got=%b addr=%h want=00011 addr=0100", n,
                         {mreq_n, rd_n, m1_n, rfsh_n, busy}, addr_bus);
            end
            tick();
        end
        data_in = 8'hFF;
        for (int n = 3; n <= 4; n++) begin
            checks++;
            if ({mreq_n, rd_n, m1_n, rfsh_n, busy, done} !== 6'b011010 || addr_bus !== 16'h3F07
                || rdata !== 8'h0A) begin
                failures++;
                $display("FAIL m1_t%0d got=%b addr=%h rdata=%h want=011010 addr=3f07 rdata=0a", n,
                         {mreq_n, rd_n, m1_n, rfsh_n, busy, done}, addr_bus, rdata);
            end
            tick();
        end
        checks++;
        if ({mreq_n, rd_n, m1_n, rfsh_n, busy, done} !== 6'b111101 || addr_bus !== 16'h3F07
            || rdata !== 8'h0A || wait_cnt !== 8'h00) begin
            failures++;
            $display("FAIL m1_done got=%b addr=%h rdata=%h wcnt=%0d want=111101 addr=3f07 rdata=0a wcnt=0",
                     {mreq_n, rd_n, m1_n, rfsh_n, busy, done}, addr_bus, rdata, wait_cnt);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        req = 1'b1; m1 = 1'b0; addr = 16'h2222; data_in = 8'h11; wait_n = 1'b1;
        tick();
        tick();
        addr = 16'h4444; m1 = 1'b1;
        checks++;
        if ({mreq_n, rd_n, m1_n, busy} !== 4'b0011 || addr_bus !== 16'h2222) begin
            failures++;
            $display("FAIL b2b_t2 got=%b addr=%h want=0011 addr=2222", {mreq_n, rd_n, m1_n, busy}, addr_bus);
        end
        tick();
        checks++;
        if ({mreq_n, rd_n, m1_n, rfsh_n} !== 4'b0011 || addr_bus !== 16'h2222) begin
            failures++;
            $display("FAIL b2b_capture got=%b addr=%h want=0011 addr=2222", {mreq_n, rd_n, m1_n, rfsh_n}, addr_bus);
        end
        tick();
        addr = 16'h3333; m1 = 1'b0; data_in = 8'h22;
        checks++;
        if (done !== 1'b1 || rdata !== 8'h11) begin
            failures++;
            $display("FAIL b2b_done1 got done=%b rdata=%h want done=1 rdata=11", done, rdata);
        end
        tick();
        req = 1'b0;
        checks++;
        if (busy !== 1'b1 || mreq_n !== 1'b0 || addr_bus !== 16'h3333 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_t1 got busy=%b mreq_n=%b addr=%h done=%b want busy=1 mreq_n=0 addr=3333 done=0",
                     busy, mreq_n, addr_bus, done);
        end
        tick();
        req = 1'b1; addr = 16'h5555;
        tick();
        req = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || rdata !== 8'h22) begin
            failures++;
            $display("FAIL b2b_done2 got done=%b rdata=%h want done=1 rdata=22", done, rdata);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || mreq_n !== 1'b1 || addr_bus !== 16'h3333) begin
            failures++;
            $display("FAIL b2b_pulse_ignored got busy=%b mreq_n=%b addr=%h want busy=0 mreq_n=1 addr=3333",
                     busy, mreq_n, addr_bus);
        end
    endtask

    task automatic test_reset_mid_cycle();
        int seen_done;
        seen_done = 0;
        req = 1'b1; m1 = 1'b1; addr = 16'h0200; ir = 16'h1111; data_in = 8'h77; wait_n = 1'b1;
        tick();
        req = 1'b0;
        tick();
        wait_n = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || m1_n !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_tw got busy=%b m1_n=%b want busy=1 m1_n=0", busy, m1_n);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({mreq_n, rd_n, m1_n, rfsh_n, busy, done} !== 6'b111100 || rdata !== 8'h00 || addr_bus !== 16'h0000) begin
            failures++;
            $display("FAIL rst_async got=%b rdata=%h addr=%h want=111100 rdata=00 addr=0000",
                     {mreq_n, rd_n, m1_n, rfsh_n, busy, done}, rdata, addr_bus);
        end
        wait_n = 1'b1;
        tick();
        reset_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (done) seen_done = 1;
        end
        checks++;
        if (seen_done !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_done got done_seen=%0d busy=%b want done_seen=0 busy=0", seen_done, busy);
        end
        req = 1'b1; m1 = 1'b0; addr = 16'h0ABC; data_in = 8'h99;
        tick();
        req = 1'b0;
        checks++;
        if (mreq_n !== 1'b0 || addr_bus !== 16'h0ABC) begin
            failures++;
            $display("FAIL rst_fresh_t1 got mreq_n=%b addr=%h want mreq_n=0 addr=0abc", mreq_n, addr_bus);
        end
        tick(); tick(); tick();
        checks++;
        if (done !== 1'b1 || rdata !== 8'h99 || wait_cnt !== 8'h00) begin
            failures++;
            $display("FAIL rst_recover got done=%b rdata=%h wcnt=%0d want done=1 rdata=99 wcnt=0",
                     done, rdata, wait_cnt);
        end
    endtask

    task automatic test_wait_saturation();
        int got_done;
        got_done = 0;
        tick();
        req = 1'b1; m1 = 1'b0; addr = 16'hBEEF; data_in = 8'h3C; wait_n = 1'b1;
        tick();
        req = 1'b0;
        wait_n = 1'b0;
        for (int n = 0; n < 300; n++) tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || wait_cnt !== 8'h00) begin
            failures++;
            $display("FAIL sat_stalled got busy=%b done=%b wcnt=%0d want busy=1 done=0 wcnt=0", busy, done, wait_cnt);
        end
        wait_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (done) begin
                got_done = 1;
                break;
            end
        end
        checks++;
        if (got_done !== 1 || wait_cnt !== 8'd255 || rdata !== 8'h3C) begin
            failures++;
            $display("FAIL sat_result got done=%0d wcnt=%0d rdata=%h want done=1 wcnt=255 rdata=3c",
                     got_done, wait_cnt, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_plain_read();
        test_wait_states();
        test_m1_fetch();
        test_back_to_back();
        test_reset_mid_cycle();
        test_wait_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/z80_mcycle_rd.md
Z80_MCYCLE_RD -- requirements
Module: z80_mcycle_rd

Interface
REQ-001 clk  input  1  core clock; one clock period equals one Z80 T-state.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 req  input  1  start request; accepted only when busy=0.
REQ-004 m1  input  1  1 selects an opcode fetch (M1) cycle; 0 selects a plain memory read; sampled at acceptance.
REQ-005 addr  input  16  read address; sampled at acceptance.
REQ-006 ir  input  16  {I,R} refresh address; sampled at acceptance.
REQ-007 data_in  input  8  external data bus.
REQ-008 wait_n  input  1  external WAIT, active-low.
REQ-009 addr_bus  output  16  external address bus.
REQ-010 mreq_n, rd_n, m1_n, rfsh_n  output  1 each  bus strobes, active-low.
REQ-011 busy  output  1  cycle in progress.
REQ-012 done  output  1  one-clock completion pulse.
REQ-013 rdata  output  8  latched read data, feeding the instruction-execute stage (e.g. LD A,(BC/DE)).
REQ-014 wait_cnt  output  8  wait states inserted in the last completed cycle, saturating at 255.

Function
REQ-015 The block SHALL implement states IDLE, T1, T2, TW, T3, T4; all outputs SHALL be registered.
REQ-016 IDLE: req=1 -> capture m1, addr, ir; clear the internal wait counter; go to T1 on the next edge.
REQ-017 T1 and T2: addr_bus=captured addr, mreq_n=0, rd_n=0, m1_n=~m1, rfsh_n=1, busy=1.
REQ-018 T2 and TW: wait_n=0 at the closing edge -> TW, with the wait counter incremented and saturating at 255; wait_n=1 -> T3.
REQ-019 TW: strobes and address SHALL be held exactly as in T2.
REQ-020 M1 fetch: rdata SHALL latch data_in on the edge leaving T2/TW into T3.
REQ-021 M1 fetch, T3 and T4: addr_bus=captured ir, mreq_n=0, rfsh_n=0, rd_n=1, m1_n=1.
REQ-022 M1 fetch, transitions: T3 -> T4; T4 -> IDLE.
REQ-023 Plain read, T3: the state SHALL hold T1/T2 strobes, and rdata SHALL latch data_in on the edge leaving T3; T3 -> IDLE.
REQ-024 done SHALL be 1 for exactly the first IDLE clock after the final T-state.
REQ-025 wait_cnt SHALL update to the counter value in that same clock and hold until the next done.
REQ-026 In the done clock, req=1 SHALL be accepted, so back-to-back cycles carry no idle gap beyond that clock.
REQ-027 req while busy=1 SHALL be ignored, and captured values SHALL NOT change.
REQ-028 Latency: plain read = 3+W clocks from T1 to done-1; M1 = 4+W clocks, where W is the number of wait states.
REQ-029 IDLE outputs: strobes=1, addr_bus holds its last value, busy=0.
REQ-030 rdata SHALL change only at the latch points in REQ-020 and REQ-023.

Reset
REQ-031 reset_n=0 SHALL asynchronously force state=IDLE, mreq_n=rd_n=m1_n=rfsh_n=1, busy=0, done=0, rdata=0x00, wait_cnt=0x00, addr_bus=0x0000.
REQ-032 Reset asserted mid-cycle (any T-state including TW) SHALL abort the cycle with no done pulse; after reset_n rises, the first req SHALL start a fresh T1.

Verification
REQ-033 Plain read: addr=0x1234, wait_n=1, data_in=0x5A -> mreq_n/rd_n low for 3 clocks; done one clock later; rdata=0x5A; wait_cnt=0.
REQ-034 Plain read with wait_n=0 for 2 T2/TW samples, addr=0x8000, data=0xC3 -> 2 TW states; done at clock 6 after acceptance; rdata=0xC3; wait_cnt=2.
REQ-035 M1 fetch: addr=0x0100, ir=0x3F07, data=0x0A -> m1_n low in T1-T2; rdata=0x0A latched entering T3; T3-T4 addr_bus=0x3F07 with rfsh_n=0, rd_n=1; done after T4.
REQ-036 Back-to-back: req held high across done -> second T1 immediately follows the done clock; a req pulse during T2 -> ignored.
REQ-037 reset_n pulsed low during TW of an M1 fetch -> strobes high immediately, no done, rdata=0x00; the next req completes normally.
REQ-038 wait_n held low for 300 clocks -> wait_cnt saturates at 255 and the cycle completes once wait_n=1.
